fetch_stage: RTL and testbench

Instruction-fetch stage sitting directly downstream of the program counter. Takes the current PC address, fetches the word from instruction memory over a req/ack handshake, and loads the IF/ID pipeline register. Produces the next-PC value (PC+4 or branch target) and a one-cycle `pc_advance` pulse that the PC register uses as its load enable.

---
 rtl/fetch_stage_pkg.sv | 19 +
 rtl/fetch_stage_ifid_reg.sv | 31 +++
 rtl/fetch_stage.sv | 178 +++++++++++++++++
 tb/tb_fetch_stage.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// rtl/fetch_stage_pkg.sv - shared types and constants for the instruction-fetch stage
package fetch_stage_pkg;

    localparam logic [31:0] NOP_WORD   = 32'h0000_0000;
    localparam logic [31:0] WORD_BYTES = 32'd4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc_plus4;
    } ifid_t;

endpackage

// File: rtl/fetch_stage_ifid_reg.sv
// rtl/fetch_stage_ifid_reg.sv - IF/ID pipeline register with load, hold and clear
module ifid_reg
    import fetch_stage_pkg::*;
(
    input  logic  CLK,
    input  logic  reset,
    input  logic  load,
    input  logic  hold,
    input  logic  clear,
    input  ifid_t d,
    output ifid_t q,
    output logic  valid
);

    // Clear wins over load; hold freezes everything; otherwise an unloaded cycle leaves a bubble
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            q     <= '0;
            valid <= 1'b0;
        end else if (clear) begin
            q     <= '{instr: NOP_WORD, pc: 32'h0, pc_plus4: 32'h0};
            valid <= 1'b0;
        end else if (load) begin
            q     <= d;
            valid <= 1'b1;
        end else if (!hold) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch over req/ack memory into IF/ID; optional FETCH_PERF_CNT_EN counters
module fetch_stage
    import fetch_stage_pkg::*;
(
    input  logic        CLK,
    input  logic        reset,
    input  logic [31:0] pc_in,
    input  logic        stall,
    input  logic        flush,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] next_pc,
    output logic        pc_advance,
    output logic [31:0] instr_out,
    output logic [31:0] pc_out,
    output logic [31:0] pc_plus4_out,
    output logic        valid_out,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0] fetch_count,
    output logic [31:0] stall_cycles,
`endif
    output logic        misalign
);

    fetch_state_t state, state_nxt;
    logic [31:0]  addr_q;
    logic [31:0]  hold_buf;
    logic         flush_pending;
    logic         adv;
    logic         ifid_load;
    ifid_t        ifid_d;
    ifid_t        ifid_q;
    logic         addr_load;
    logic         buf_load;
    logic         set_pending;
    logic         clr_pending;
    logic         set_mis;

    // Next PC for the PC register; wraps naturally at 2^32
    always_comb begin
        next_pc = branch_taken ? branch_target : (pc_in + WORD_BYTES);
    end

    // FSM state register
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state and per-cycle control strobes
    always_comb begin
        state_nxt   = state;
        adv         = 1'b0;
        ifid_load   = 1'b0;
        ifid_d      = '{instr: NOP_WORD, pc: pc_in, pc_plus4: pc_in + WORD_BYTES};
        addr_load   = 1'b0;
        buf_load    = 1'b0;
        set_pending = 1'b0;
        clr_pending = 1'b0;
        set_mis     = 1'b0;
        case (state)
            IDLE: begin
                if (!stall && !flush) begin
                    if (pc_in[1:0] != 2'b00) begin
                        // Misaligned PC: retire a NOP in place of a memory access
                        set_mis   = 1'b1;
                        ifid_load = 1'b1;
                        adv       = 1'b1;
                    end else begin
                        addr_load = 1'b1;
                        state_nxt = REQ;
                    end
                end
            end
            REQ: begin
                if (imem_ack) begin
                    if (flush || flush_pending) begin
                        clr_pending = 1'b1;
                        state_nxt   = IDLE;
                    end else if (stall) begin
                        buf_load  = 1'b1;
                        state_nxt = HOLD;
                    end else begin
                        ifid_load = 1'b1;
                        ifid_d    = '{instr: imem_rdata, pc: addr_q, pc_plus4: addr_q + WORD_BYTES};
                        adv       = 1'b1;
                        state_nxt = IDLE;
                    end
                end else if (flush) begin
                    // Memory cannot be aborted; remember to drop the word when it lands
                    set_pending = 1'b1;
                end
            end
            HOLD: begin
                if (flush) begin
                    state_nxt = IDLE;
                end else if (!stall) begin
                    ifid_load = 1'b1;
                    ifid_d    = '{instr: hold_buf, pc: addr_q, pc_plus4: addr_q + WORD_BYTES};
                    adv       = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign imem_req   = (state == REQ);
    assign imem_addr  = addr_q;
    assign pc_advance = adv & ~reset;

    // Fetch address, hold buffer, pending-flush and sticky misalign flags
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            addr_q        <= 32'h0;
            hold_buf      <= NOP_WORD;
            flush_pending <= 1'b0;
            misalign      <= 1'b0;
        end else begin
            if (addr_load) begin
                addr_q <= pc_in;
            end
            if (buf_load) begin
                hold_buf <= imem_rdata;
            end
            if (clr_pending) begin
                flush_pending <= 1'b0;
            end else if (set_pending) begin
                flush_pending <= 1'b1;
            end
            if (set_mis) begin
                misalign <= 1'b1;
            end
        end
    end

    ifid_reg u_ifid (
        .CLK   (CLK),
        .reset (reset),
        .load  (ifid_load),
        .hold  (stall),
        .clear (flush),
        .d     (ifid_d),
        .q     (ifid_q),
        .valid (valid_out)
    );

    assign instr_out    = ifid_q.instr;
    assign pc_out       = ifid_q.pc;
    assign pc_plus4_out = ifid_q.pc_plus4;

`ifdef FETCH_PERF_CNT_EN
    // Accepted-instruction and stall-cycle counters, free-running with wrap
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            fetch_count  <= 32'h0;
            stall_cycles <= 32'h0;
        end else begin
            if (adv) begin
                fetch_count <= fetch_count + 32'd1;
            end
            if ((state == HOLD) || ((state == IDLE) && stall)) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - self-checking bench for fetch_stage with directed and random stimulus
module tb_fetch_stage;

    logic        CLK = 1'b0;
    logic        reset;
    logic [31:0] pc_in;
    logic        stall;
    logic        flush;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] next_pc;
    logic        pc_advance;
    logic [31:0] instr_out;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4_out;
    logic        valid_out;
    logic        misalign;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_count;
    logic [31:0] stall_cycles;
`endif

    always #5 CLK = ~CLK;

    fetch_stage dut (
        .CLK           (CLK),
        .reset         (reset),
        .pc_in         (pc_in),
        .stall         (stall),
        .flush         (flush),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .next_pc       (next_pc),
        .pc_advance    (pc_advance),
        .instr_out     (instr_out),
        .pc_out        (pc_out),
        .pc_plus4_out  (pc_plus4_out),
        .valid_out     (valid_out),
`ifdef FETCH_PERF_CNT_EN
        .fetch_count   (fetch_count),
        .stall_cycles  (stall_cycles),
`endif
        .misalign      (misalign)
    );

    int total = 0;
    int bad   = 0;
    int cfg_delay = 0;
    int mem_wait  = 0;
    int acks = 0;
    int advs = 0;
    logic auto_pc = 1'b1;
    logic t_adv, t_req, t_ack;
    logic [31:0] t_addr;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h2001_0005 ^ (a * 32'h9E37_79B9);
    endfunction

    // One clock cycle: memory responds, combinational outputs checked mid-cycle, registered ones after the edge
    task automatic tick();
        logic [31:0] exp_next, exp_pc, exp_instr, s_instr, s_pc, s_p4;
        logic        s_valid, was_stall, was_flush;
        if (imem_req && mem_wait == 0) begin
            imem_ack   = 1'b1;
            imem_rdata = mem_word(imem_addr);
        end else begin
            if (imem_req) mem_wait--;
            imem_ack   = 1'b0;
            imem_rdata = 32'hDEAD_BEEF;
        end
        @(negedge CLK);
        t_req  = imem_req;
        t_ack  = imem_ack;
        t_addr = imem_addr;
        t_adv  = pc_advance;
        exp_next = branch_taken ? branch_target : pc_in + 32'd4;
        check_eq("next_pc", next_pc, exp_next);
        if (flush) check_eq("adv_on_flush", pc_advance, 1'b0);
        if (stall) check_eq("adv_on_stall", pc_advance, 1'b0);
        exp_pc    = pc_in;
        exp_instr = (pc_in[1:0] != 2'b00) ? 32'h0 : mem_word(pc_in);
        s_instr = instr_out; s_pc = pc_out; s_p4 = pc_plus4_out; s_valid = valid_out;
        was_stall = stall; was_flush = flush;
        if (imem_ack) acks++;
        if (pc_advance) advs++;
        @(posedge CLK);
        #1;
        if (t_adv) begin
            check_eq("ld_valid", valid_out, 1'b1);
            check_eq("ld_pc", pc_out, exp_pc);
            check_eq("ld_pc4", pc_plus4_out, exp_pc + 32'd4);
            check_eq("ld_instr", instr_out, exp_instr);
            if (auto_pc) pc_in = exp_next;
        end
        if (was_flush) begin
            check_eq("flush_valid", valid_out, 1'b0);
        end else if (was_stall) begin
            check_eq("hold_valid", valid_out, s_valid);
            check_eq("hold_instr", instr_out, s_instr);
            check_eq("hold_pc", pc_out, s_pc);
            check_eq("hold_pc4", pc_plus4_out, s_p4);
        end
        if (t_req && !t_ack) begin
            check_eq("req_held", imem_req, 1'b1);
            check_eq("addr_stable", imem_addr, t_addr);
        end
        if (t_ack) begin
            check_eq("req_drop", imem_req, 1'b0);
            mem_wait = (cfg_delay < 0) ? int'($urandom_range(3, 0)) : cfg_delay;
        end
    endtask

    initial begin
        int reqs, nadv, a0, k0, n, done;
        logic [31:0] r;
`ifdef FETCH_PERF_CNT_EN
        logic [31:0] fc0, sc0;
`endif
        reset = 1'b1; pc_in = 32'h0; stall = 1'b0; flush = 1'b0;
        branch_taken = 1'b0; branch_target = 32'h0; imem_ack = 1'b0; imem_rdata = 32'h0;
        repeat (2) @(posedge CLK);
        #1;
        check_eq("rst_req", imem_req, 1'b0);
        check_eq("rst_valid", valid_out, 1'b0);
        check_eq("rst_adv", pc_advance, 1'b0);
        check_eq("rst_mis", misalign, 1'b0);
        check_eq("rst_instr", instr_out, 32'h0);
        reset = 1'b0;

        // zero-wait fetch from 0
        tick();
        check_eq("zw_c1_adv", t_adv, 1'b0);
        tick();
        check_eq("zw_c2_req", t_req, 1'b1);
        check_eq("zw_c2_adv", t_adv, 1'b1);
        check_eq("zw_instr", instr_out, 32'h2001_0005);
        check_eq("zw_pc4", pc_plus4_out, 32'h4);
        check_eq("zw_pcin", pc_in, 32'h4);

        // memory answers after three wait cycles
        mem_wait = 3; cfg_delay = 0;
        reqs = 0; nadv = 0; done = 0;
        for (int i = 0; i < 20 && done == 0; i++) begin
            tick();
            reqs += int'(t_req);
            nadv += int'(t_adv);
            if (t_ack) done = 1;
        end
        check_eq("dly_done", done, 1);
        check_eq("dly_reqs", reqs, 4);
        check_eq("dly_advs", nadv, 1);

        // stall raised at ack, held four more cycles
`ifdef FETCH_PERF_CNT_EN
        fc0 = fetch_count; sc0 = stall_cycles;
`endif
        mem_wait = 0;
        tick();
        stall = 1'b1;
        tick();
        check_eq("st_ack", t_ack, 1'b1);
        nadv = 0;
        repeat (4) begin
            tick();
            nadv += int'(t_adv);
        end
        check_eq("st_hold_adv", nadv, 0);
        stall = 1'b0;
        tick();
        check_eq("st_rel_adv", t_adv, 1'b1);
        check_eq("st_rel_valid", valid_out, 1'b1);
`ifdef FETCH_PERF_CNT_EN
        check_eq("st_fcnt", fetch_count - fc0, 32'd1);
        check_eq("st_scyc", stall_cycles - sc0, 32'd5);
`endif

        // flush while waiting on memory: word is discarded
        mem_wait = 2;
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        nadv = 0; done = 0;
        for (int i = 0; i < 20 && done == 0; i++) begin
            tick();
            nadv += int'(t_adv);
            if (t_ack) done = 1;
        end
        check_eq("fl_done", done, 1);
        check_eq("fl_advs", nadv, 0);
        check_eq("fl_valid", valid_out, 1'b0);

        // next_pc selection and wrap
        stall = 1'b1;
        pc_in = 32'hFFFF_FFFC;
        #1 check_eq("np_wrap", next_pc, 32'h0);
        branch_taken = 1'b1; branch_target = 32'h0000_0100;
        #1 check_eq("np_branch", next_pc, 32'h100);
        branch_taken = 1'b0;
        stall = 1'b0;

        // misaligned PC retires a NOP without touching memory
        pc_in = 32'h0000_0002;
        tick();
        check_eq("mis_req", t_req, 1'b0);
        check_eq("mis_adv", t_adv, 1'b1);
        check_eq("mis_instr", instr_out, 32'h0);
        check_eq("mis_flag", misalign, 1'b1);
        pc_in = 32'h0000_0100;
        mem_wait = 0;
        tick();
        tick();
        check_eq("mis_fetch_adv", t_adv, 1'b1);
        check_eq("mis_sticky", misalign, 1'b1);

        // reset in the middle of an outstanding request
        mem_wait = 5;
        tick();
        tick();
        check_eq("rm_req_pre", imem_req, 1'b1);
        reset = 1'b1;
        #1;
        check_eq("rm_req", imem_req, 1'b0);
        check_eq("rm_mis", misalign, 1'b0);
        check_eq("rm_valid", valid_out, 1'b0);
        @(posedge CLK);
        #1;
        reset = 1'b0;
        pc_in = 32'h0;
        mem_wait = 0;

        // random stalls, branches and memory latency
        cfg_delay = -1;
        a0 = acks; k0 = advs;
`ifdef FETCH_PERF_CNT_EN
        fc0 = fetch_count;
`endif
        for (int i = 0; i < 400; i++) begin
            stall = ($urandom_range(3, 0) == 0);
            branch_taken = ($urandom_range(5, 0) == 0);
            r = $urandom;
            branch_target = r & 32'hFFFF_FFFC;
            tick();
        end
        stall = 1'b0; branch_taken = 1'b0;
        done = 0;
        for (int i = 0; i < 20 && done == 0; i++) begin
            tick();
            if (t_adv) done = 1;
        end
        check_eq("rnd_drain", done, 1);
        n = advs - k0;
        check_eq("rnd_acks_eq_advs", acks - a0, n);
        check_eq("rnd_progress", (n >= 30), 1'b1);
`ifdef FETCH_PERF_CNT_EN
        check_eq("rnd_fcnt", fetch_count - fc0, n);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
